// File: rtl/hamming_stream_checker_if.sv
// Beat-level handshake bundle for the Hamming stream checker: upstream offer
// (payload + parity code) and downstream checked beat (payload + syndrome).
interface hamming_stream_checker_if #(
    parameter int DATA_WIDTH = 8
);
    // Smallest p with 2^p >= DATA_WIDTH + p + 1; the descending scan leaves the smallest match.
    function automatic int parity_width_for(input int dw);
        int r;
        r = 1;
        for (int p = 30; p >= 1; p--) begin
            if ((1 << p) >= dw + p + 1) begin
                r = p;
            end
        end
        return r;
    endfunction

    localparam int PARITY_WIDTH = parity_width_for(DATA_WIDTH);

    logic                    upstream_valid;
    logic                    upstream_ready;
    logic [DATA_WIDTH-1:0]   upstream_data;
    logic [PARITY_WIDTH-1:0] upstream_code;
    logic                    downstream_valid;
    logic                    downstream_ready;
    logic [DATA_WIDTH-1:0]   downstream_data;
    logic                    downstream_error;
    logic [PARITY_WIDTH-1:0] downstream_syndrome;

    modport master (
        output upstream_valid, upstream_data, upstream_code, downstream_ready,
        input  upstream_ready, downstream_valid, downstream_data,
               downstream_error, downstream_syndrome
    );

    modport slave (
        input  upstream_valid, upstream_data, upstream_code, downstream_ready,
        output upstream_ready, downstream_valid, downstream_data,
               downstream_error, downstream_syndrome
    );
endinterface

// File: rtl/hamming_stream_checker.sv
// Checks the Hamming syndrome of each streamed beat through a one-entry output
// stage and keeps a saturating errored-beat counter plus a sticky error flag.
module hamming_stream_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    hamming_stream_checker_if.slave  bus,
    input  logic                     clear,
    output logic [COUNTER_WIDTH-1:0] error_count,
    output logic                     error_sticky
);
    function automatic int parity_width_for(input int dw);
        int r;
        r = 1;
        for (int p = 30; p >= 1; p--) begin
            if ((1 << p) >= dw + p + 1) begin
                r = p;
            end
        end
        return r;
    endfunction

    localparam int PARITY_WIDTH = parity_width_for(DATA_WIDTH);

    // 1-indexed block position of data bit j: the j-th non-power-of-two position.
    function automatic int data_position(input int j, input int pw);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int q = 1; q < (1 << pw); q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == j) begin
                    pos = q;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [PARITY_WIDTH-1:0] data_terms [DATA_WIDTH];
    logic [PARITY_WIDTH-1:0] beat_syndrome;
    logic                    beat_error;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_term
            localparam logic [PARITY_WIDTH-1:0] POS = PARITY_WIDTH'(data_position(gi, PARITY_WIDTH));
            assign data_terms[gi] = bus.upstream_data[gi] ? POS : '0;
        end
    endgenerate

    // Parity bit i sits at position 2^i, so the code word itself is the XOR of the parity positions.
    always_comb begin
        beat_syndrome = bus.upstream_code;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            beat_syndrome = beat_syndrome ^ data_terms[i];
        end
    end

    assign beat_error = |beat_syndrome;

    logic                     valid_reg, valid_next;
    logic [DATA_WIDTH-1:0]    data_reg, data_next;
    logic [PARITY_WIDTH-1:0]  syndrome_reg, syndrome_next;
    logic                     error_reg, error_next;
    logic [COUNTER_WIDTH-1:0] count_reg, count_next, count_base;
    logic                     sticky_reg, sticky_next;
    logic                     ready;
    logic                     accept;
    logic                     consume;

    assign ready   = !valid_reg || bus.downstream_ready;
    assign accept  = bus.upstream_valid && ready;
    assign consume = valid_reg && bus.downstream_ready;

    always_comb begin
        valid_next    = valid_reg;
        data_next     = data_reg;
        syndrome_next = syndrome_reg;
        error_next    = error_reg;
        if (accept) begin
            valid_next    = 1'b1;
            data_next     = bus.upstream_data;
            syndrome_next = beat_syndrome;
            error_next    = beat_error;
        end else if (consume) begin
            valid_next = 1'b0;
        end
    end

    // Clear applies first so a coinciding errored beat still lands as the first count.
    always_comb begin
        count_base  = clear ? '0 : count_reg;
        count_next  = count_base;
        if (accept && beat_error && (count_base != {COUNTER_WIDTH{1'b1}})) begin
            count_next = count_base + COUNTER_WIDTH'(1);
        end
        sticky_next = (clear ? 1'b0 : sticky_reg) | (accept && beat_error);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            syndrome_reg <= '0;
            error_reg    <= 1'b0;
            count_reg    <= '0;
            sticky_reg   <= 1'b0;
        end else begin
            valid_reg    <= valid_next;
            data_reg     <= data_next;
            syndrome_reg <= syndrome_next;
            error_reg    <= error_next;
            count_reg    <= count_next;
            sticky_reg   <= sticky_next;
        end
    end

    assign bus.upstream_ready      = ready;
    assign bus.downstream_valid    = valid_reg;
    assign bus.downstream_data     = data_reg;
    assign bus.downstream_syndrome = syndrome_reg;
    assign bus.downstream_error    = error_reg;
    assign error_count             = count_reg;
    assign error_sticky            = sticky_reg;
endmodule

// File: tb/tb_hamming_stream_checker.sv
// Directed plus randomized bench: two checkers (2-bit and 16-bit counters) share
// one stimulus stream and are compared each cycle against a queue-based model.
module tb_hamming_stream_checker;
    localparam int DW   = 8;
    localparam int PW   = 4;
    localparam int CW_A = 2;
    localparam int CW_B = 16;

    logic            clock  = 1'b0;
    logic            resetn = 1'b0;
    logic            clear  = 1'b0;
    logic [CW_A-1:0] count_a;
    logic            sticky_a;
    logic [CW_B-1:0] count_b;
    logic            sticky_b;

    hamming_stream_checker_if #(.DATA_WIDTH(DW)) bus_a ();
    hamming_stream_checker_if #(.DATA_WIDTH(DW)) bus_b ();

    assign bus_b.upstream_valid   = bus_a.upstream_valid;
    assign bus_b.upstream_data    = bus_a.upstream_data;
    assign bus_b.upstream_code    = bus_a.upstream_code;
    assign bus_b.downstream_ready = bus_a.downstream_ready;

    hamming_stream_checker #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW_A)) dut_a (
        .clock(clock), .resetn(resetn), .bus(bus_a.slave),
        .clear(clear), .error_count(count_a), .error_sticky(sticky_a)
    );

    hamming_stream_checker #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW_B)) dut_b (
        .clock(clock), .resetn(resetn), .bus(bus_b.slave),
        .clear(clear), .error_count(count_b), .error_sticky(sticky_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        logic [PW-1:0] code;
    } beat_t;

    int vectors     = 0;
    int miscompares = 0;

    beat_t         pending[$];
    logic [DW-1:0] seen[$];
    int            consumed_n = 0;

    bit            m_held   = 1'b0;
    bit            m_zero   = 1'b1;
    logic [DW-1:0] m_data   = '0;
    logic [PW-1:0] m_syn    = '0;
    int            m_cnt_a  = 0;
    int            m_cnt_b  = 0;
    bit            m_sticky = 1'b0;

    // Build the Hamming block position by position and XOR the indices of set bits.
    function automatic logic [PW-1:0] ref_syndrome(input logic [DW-1:0] d, input logic [PW-1:0] c);
        int syn;
        int di;
        bit b;
        syn = 0;
        di  = 0;
        for (int pos = 1; pos < (1 << PW); pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                b = c[$clog2(pos)];
            end else begin
                b = (di < DW) ? d[di] : 1'b0;
                di++;
            end
            if (b) syn = syn ^ pos;
        end
        return PW'(syn);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [PW-1:0] c);
        beat_t b;
        b.data = d;
        b.code = c;
        pending.push_back(b);
    endtask

    task automatic cycle(input bit dready, input bit offer, input bit clr);
        bit            rdy;
        bit            acc;
        bit            cons;
        logic [PW-1:0] s;
        bus_a.downstream_ready = dready;
        clear                  = clr;
        bus_a.upstream_valid   = offer && (pending.size() > 0);
        if (pending.size() > 0) begin
            bus_a.upstream_data = pending[0].data;
            bus_a.upstream_code = pending[0].code;
        end
        #1;
        rdy = !m_held || dready;
        check("upstream_ready", 32'(bus_a.upstream_ready), 32'(rdy));
        check("upstream_ready_b", 32'(bus_b.upstream_ready), 32'(rdy));
        acc  = bus_a.upstream_valid && rdy && resetn;
        cons = m_held && dready && resetn;
        if (cons) begin
            consumed_n++;
            seen.push_back(bus_a.downstream_data);
        end
        @(posedge clock);
        #1;
        if (!resetn) begin
            m_held = 0; m_zero = 1; m_data = '0; m_syn = '0;
            m_cnt_a = 0; m_cnt_b = 0; m_sticky = 0;
        end else begin
            if (clr) begin
                m_cnt_a = 0; m_cnt_b = 0; m_sticky = 0;
            end
            if (acc) begin
                s = ref_syndrome(pending[0].data, pending[0].code);
                if (s != 0) begin
                    m_cnt_a  = (m_cnt_a + 1 > (1 << CW_A) - 1) ? (1 << CW_A) - 1 : m_cnt_a + 1;
                    m_cnt_b  = (m_cnt_b + 1 > (1 << CW_B) - 1) ? (1 << CW_B) - 1 : m_cnt_b + 1;
                    m_sticky = 1;
                end
                m_held = 1; m_zero = 0;
                m_data = pending[0].data;
                m_syn  = s;
                void'(pending.pop_front());
            end else if (cons) begin
                m_held = 0;
            end
        end
        check("dn_valid", 32'(bus_a.downstream_valid), 32'(m_held));
        check("dn_valid_b", 32'(bus_b.downstream_valid), 32'(m_held));
        if (m_held || m_zero) begin
            check("dn_data", 32'(bus_a.downstream_data), 32'(m_data));
            check("dn_syndrome", 32'(bus_a.downstream_syndrome), 32'(m_syn));
            check("dn_error", 32'(bus_a.downstream_error), 32'(m_syn != 0));
            check("dn_data_b", 32'(bus_b.downstream_data), 32'(m_data));
            check("dn_syndrome_b", 32'(bus_b.downstream_syndrome), 32'(m_syn));
            check("dn_error_b", 32'(bus_b.downstream_error), 32'(m_syn != 0));
        end
        check("count_a", 32'(count_a), 32'(m_cnt_a));
        check("count_b", 32'(count_b), 32'(m_cnt_b));
        check("sticky_a", 32'(sticky_a), 32'(m_sticky));
        check("sticky_b", 32'(sticky_b), 32'(m_sticky));
    endtask

    initial begin
        int            sat_exp[5] = '{1, 2, 3, 3, 3};
        logic [DW-1:0] sent[$];
        logic [DW-1:0] held_data;
        int            base;

        bus_a.upstream_valid   = 1'b0;
        bus_a.upstream_data    = '0;
        bus_a.upstream_code    = '0;
        bus_a.downstream_ready = 1'b0;

        // Reset state
        resetn = 1'b0;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        resetn = 1'b1;

        // Clean beat
        push(8'hA5, 4'h3);
        cycle(1, 1, 0);
        check("clean_valid", 32'(bus_a.downstream_valid), 32'd1);
        check("clean_data", 32'(bus_a.downstream_data), 32'hA5);
        check("clean_error", 32'(bus_a.downstream_error), 32'd0);
        check("clean_syndrome", 32'(bus_a.downstream_syndrome), 32'h0);
        check("clean_count", 32'(count_a), 32'd0);

        // Single-bit data errors
        push(8'h25, 4'h3);
        cycle(1, 1, 0);
        check("err_syndrome", 32'(bus_a.downstream_syndrome), 32'hC);
        check("err_error", 32'(bus_a.downstream_error), 32'd1);
        check("err_count", 32'(count_a), 32'd1);
        check("err_sticky", 32'(sticky_a), 32'd1);
        push(8'h01, 4'h0);
        cycle(1, 1, 0);
        check("err2_syndrome", 32'(bus_a.downstream_syndrome), 32'h3);
        cycle(1, 0, 0);

        // Backpressure: four back-to-back beats with the consumer stalled for three cycles
        seen.delete();
        sent.delete();
        base = consumed_n;
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            sent.push_back(d);
            push(d, PW'($urandom));
        end
        cycle(0, 1, 0);
        held_data = bus_a.downstream_data;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0);
            check("bp_hold_data", 32'(bus_a.downstream_data), 32'(held_data));
            check("bp_ready_low", 32'(bus_a.upstream_ready), 32'd0);
        end
        for (int i = 0; i < 10 && (pending.size() > 0 || m_held); i++) begin
            cycle(1, 1, 0);
        end
        check("bp_drained", 32'(pending.size() == 0 && !m_held), 32'd1);
        check("bp_consumed", 32'(consumed_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("bp_order", 32'(i < seen.size() ? seen[i] : 'x), 32'(sent[i]));
        end

        // Saturation of the 2-bit counter
        cycle(1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            push(8'h25, 4'h3);
            cycle(1, 1, 0);
            check("sat_count", 32'(count_a), 32'(sat_exp[i]));
        end

        // Clear coinciding with an errored beat, then clear alone
        push(8'h01, 4'h0);
        cycle(1, 1, 1);
        check("clr_err_count", 32'(count_a), 32'd1);
        check("clr_err_sticky", 32'(sticky_a), 32'd1);
        cycle(1, 0, 1);
        check("clr_count", 32'(count_a), 32'd0);
        check("clr_sticky", 32'(sticky_a), 32'd0);

        // Reset while an errored beat is held
        push(8'h25, 4'h3);
        cycle(0, 1, 0);
        push(8'h01, 4'h0);
        resetn = 1'b0;
        cycle(0, 1, 0);
        check("rst_valid", 32'(bus_a.downstream_valid), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_sticky", 32'(sticky_a), 32'd0);
        resetn = 1'b1;
        pending.delete();
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
        end
        check("rst_no_ghost", 32'(seen.size()), 32'd0);

        // Randomized traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            if (pending.size() < 3) push(DW'($urandom), PW'($urandom));
            resetn = ($urandom_range(0, 99) != 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        resetn = 1'b1;
        cycle(1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
